// File: rtl/jesd204b_tpl_framer.sv
// jesd204b_tpl_framer
// JESD204B transport-layer framer. Packs one frame (SAMPLES samples per
// converter) per beat into LANES lane words, with control-bit insertion,
// tail padding, dummy-converter zero fill, ramp / checkerboard test patterns
// and multiframe position tracking. Two-stage valid/ready pipeline:
// S1 packs the accepted beat, S2 is the output register.
//
// Ports
//   clk           frame clock, rising edge
//   rst_n         asynchronous active-low reset
//   tx_datain     samples, conv c / sample s at [(c*S+s)*N +: N]
//   tx_ctrlin     control bits, same indexing with width CS
//   tx_mode       00 normal, 01 ramp, 10 checkerboard, 11 normal
//   in_valid      input beat valid
//   in_ready      framer can accept a beat
//   mf_clear      synchronous clear of the multiframe frame counter
//   tx_dataout    lane l at [l*LANE_W +: LANE_W]
//   out_valid     tx_dataout holds a frame
//   out_ready     downstream accepts the frame
//   out_somf      current output frame is first of a multiframe
//   out_frame_cnt frame index within the multiframe
//
// CONTROL must be at least 1 (a zero-width control port is not legal).

module jesd204b_tpl_framer #(
   parameter int LANES         = 4,
   parameter int CONVERTERS    = 8,
   parameter int RESOLUTION    = 11,
   parameter int CONTROL       = 2,
   parameter int SAMPLE_SIZE   = 16,
   parameter int SAMPLES       = 1,
   parameter int FRAMES_PER_MF = 32,
   localparam int CONV_PAD = ((CONVERTERS + LANES - 1) / LANES) * LANES,
   localparam int CPL      = CONV_PAD / LANES,
   localparam int LANE_W   = SAMPLES * SAMPLE_SIZE * CPL,
   localparam int FRAME_W  = LANES * LANE_W
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic [SAMPLES*CONVERTERS*RESOLUTION-1:0] tx_datain,
   input  logic [SAMPLES*CONVERTERS*CONTROL-1:0]    tx_ctrlin,
   input  logic [1:0]                               tx_mode,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic                                     mf_clear,
   output logic [FRAME_W-1:0]                       tx_dataout,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic                                     out_somf,
   output logic [4:0]                               out_frame_cnt
);

   localparam int PAD_BITS = SAMPLE_SIZE - RESOLUTION - CONTROL;

   logic                  s1_v_q, s1_v_d;
   logic                  s2_v_q, s2_v_d;
   logic [FRAME_W-1:0]    s1_data_q, s1_data_d;
   logic [FRAME_W-1:0]    s2_data_q, s2_data_d;
   logic [RESOLUTION-1:0] ramp_q, ramp_d;
   logic                  parity_q, parity_d;
   logic [4:0]            frame_cnt_q, frame_cnt_d;

   logic                  accept;
   logic                  s2_adv;
   logic [FRAME_W-1:0]    frame_pack;
   logic [RESOLUTION-1:0] smp_data;
   logic [CONTROL-1:0]    smp_ctrl;
   logic [SAMPLE_SIZE-1:0] smp_word;

   assign s2_adv   = ~s2_v_q | out_ready;
   assign in_ready = rst_n & (~s1_v_q | ~s2_v_q | out_ready);
   assign accept   = in_valid & in_ready;

   // Frame packing from the live inputs; the result is captured into S1 on accept,
   // so the mode and pattern state are effectively sampled with the beat.
   always_comb begin
      frame_pack = '0;
      smp_data   = '0;
      smp_ctrl   = '0;
      smp_word   = '0;
      for (int c = 0; c < CONV_PAD; c++) begin
         for (int s = 0; s < SAMPLES; s++) begin
            smp_word = '0;
            if (c < CONVERTERS) begin
               if (tx_mode == 2'b01) begin
                  smp_data = ramp_q;
                  smp_ctrl = '0;
               end else begin
                  smp_data = tx_datain[(c*SAMPLES+s)*RESOLUTION +: RESOLUTION];
                  smp_ctrl = tx_ctrlin[(c*SAMPLES+s)*CONTROL +: CONTROL];
               end
               smp_word = SAMPLE_SIZE'({smp_data, smp_ctrl}) << PAD_BITS;
            end
            // Lowest converter / sample 0 sits at the lane MSB.
            frame_pack[(c/CPL)*LANE_W + LANE_W - (((c%CPL)*SAMPLES + s) + 1)*SAMPLE_SIZE
                       +: SAMPLE_SIZE] = smp_word;
         end
      end
      if (tx_mode == 2'b10) begin
         for (int b = 0; b < FRAME_W; b++) begin
            frame_pack[b] = parity_q ? ((b % 2) == 1) : ((b % 2) == 0);
         end
      end
   end

   always_comb begin
      s1_v_d      = s1_v_q;
      s1_data_d   = s1_data_q;
      s2_v_d      = s2_v_q;
      s2_data_d   = s2_data_q;
      ramp_d      = ramp_q;
      parity_d    = parity_q;
      frame_cnt_d = frame_cnt_q;

      if (s2_adv) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            s2_data_d = s1_data_q;
         end
      end

      if (accept) begin
         s1_v_d    = 1'b1;
         s1_data_d = frame_pack;
         ramp_d    = (tx_mode == 2'b01) ? ramp_q + 1'b1 : '0;
         parity_d  = (tx_mode == 2'b10) ? ~parity_q : 1'b0;
      end else if (s2_adv) begin
         s1_v_d = 1'b0;
      end

      // Clear wins over a same-cycle increment; pipeline contents are untouched.
      if (mf_clear) begin
         frame_cnt_d = '0;
      end else if (s2_v_q & out_ready) begin
         frame_cnt_d = (frame_cnt_q == 5'(FRAMES_PER_MF - 1)) ? 5'd0 : frame_cnt_q + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q      <= 1'b0;
         s2_v_q      <= 1'b0;
         s1_data_q   <= '0;
         s2_data_q   <= '0;
         ramp_q      <= '0;
         parity_q    <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         s1_v_q      <= s1_v_d;
         s2_v_q      <= s2_v_d;
         s1_data_q   <= s1_data_d;
         s2_data_q   <= s2_data_d;
         ramp_q      <= ramp_d;
         parity_q    <= parity_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign tx_dataout    = s2_data_q;
   assign out_valid     = s2_v_q;
   assign out_frame_cnt = frame_cnt_q;
   assign out_somf      = (frame_cnt_q == 5'd0);

endmodule

// File: tb/tb_jesd204b_tpl_framer.sv
// Testbench for jesd204b_tpl_framer: a default-parameter instance (M=8, L=4,
// K=32) and a small instance (M=3, L=2, K=4) for dummy fill and multiframe wrap.
module tb_jesd204b_tpl_framer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [87:0]  a_datain;
   logic [15:0]  a_ctrlin;
   logic [1:0]   a_mode;
   logic         a_in_valid, a_in_ready, a_mf_clear;
   logic [127:0] a_dataout;
   logic         a_out_valid, a_out_ready, a_somf;
   logic [4:0]   a_cnt;

   logic [32:0]  b_datain;
   logic [5:0]   b_ctrlin;
   logic [1:0]   b_mode;
   logic         b_in_valid, b_in_ready, b_mf_clear;
   logic [63:0]  b_dataout;
   logic         b_out_valid, b_out_ready, b_somf;
   logic [4:0]   b_cnt;

   int checks = 0;
   int failures = 0;

   jesd204b_tpl_framer u_dut_a (
      .clk(clk), .rst_n(rst_n), .tx_datain(a_datain), .tx_ctrlin(a_ctrlin),
      .tx_mode(a_mode), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .mf_clear(a_mf_clear), .tx_dataout(a_dataout), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_somf(a_somf), .out_frame_cnt(a_cnt));

   jesd204b_tpl_framer #(.LANES(2), .CONVERTERS(3), .FRAMES_PER_MF(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .tx_datain(b_datain), .tx_ctrlin(b_ctrlin),
      .tx_mode(b_mode), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .mf_clear(b_mf_clear), .tx_dataout(b_dataout), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_somf(b_somf), .out_frame_cnt(b_cnt));

   // Reference frame: build the list of 16-bit sample words per converter,
   // then concatenate words into lanes (first converter leftmost) and place lanes.
   function automatic logic [127:0] model_frame(int m, int nl, logic [1:0] mode,
                                                logic [87:0] data, logic [15:0] ctrl,
                                                int ramp, int par);
      int conv_pad = ((m + nl - 1) / nl) * nl;
      int cpl = conv_pad / nl;
      int total = conv_pad * 16;
      logic [15:0] w [16];
      logic [127:0] lane_bits;
      logic [127:0] res;
      res = '0;
      if (mode == 2'b10) begin
         for (int b = 0; b < total; b++) res[b] = (par != 0) ? ((b % 2) == 1) : ((b % 2) == 0);
         return res;
      end
      for (int c = 0; c < conv_pad; c++) begin
         if (c >= m) w[c] = 16'h0;
         else if (mode == 2'b01) w[c] = 16'(ramp * 32);
         else w[c] = {data[c*11 +: 11], ctrl[c*2 +: 2], 3'b000};
      end
      for (int ln = 0; ln < nl; ln++) begin
         lane_bits = '0;
         for (int j = 0; j < cpl; j++) lane_bits = (lane_bits << 16) | 128'(w[ln*cpl + j]);
         res = res | (lane_bits << (ln * cpl * 16));
      end
      return res;
   endfunction

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_a();
      a_datain = {$urandom, $urandom, $urandom};
      a_ctrlin = 16'($urandom);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_in_valid = 1'b0; a_out_ready = 1'b1; a_mf_clear = 1'b0; a_mode = 2'b00;
      b_in_valid = 1'b0; b_out_ready = 1'b1; b_mf_clear = 1'b0; b_mode = 2'b00;
      a_datain = '0; a_ctrlin = '0; b_datain = '0; b_ctrlin = '0;
      repeat (3) next();
      a_in_valid = 1'b1;
      #1;
      checks++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_dataout !== 128'h0) begin
         failures++;
         $display("FAIL reset_a: in_ready=%b out_valid=%b data=%h, required 0 0 0",
                  a_in_ready, a_out_valid, a_dataout);
      end
      checks++;
      if (a_cnt !== 5'd0 || a_somf !== 1'b1) begin
         failures++;
         $display("FAIL reset_cnt: cnt=%0d somf=%b, required 0 1", a_cnt, a_somf);
      end
      checks++;
      if (b_out_valid !== 1'b0 || b_dataout !== 64'h0 || b_in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_b: out_valid=%b data=%h in_ready=%b, required 0 0 0",
                  b_out_valid, b_dataout, b_in_ready);
      end
      a_in_valid = 1'b0;
      rst_n = 1'b1;
      next();
   endtask

   task automatic test_vector();
      logic [127:0] exp;
      rand_a();
      a_datain[10:0]  = 11'h61b; a_ctrlin[1:0] = 2'b01;
      a_datain[21:11] = 11'h71b; a_ctrlin[3:2] = 2'b00;
      exp = model_frame(8, 4, 2'b00, a_datain, a_ctrlin, 0, 0);
      a_mode = 2'b00; a_in_valid = 1'b1; a_out_ready = 1'b1;
      next();
      a_in_valid = 1'b0;
      next();
      #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_dataout[31:0] !== 32'hC368_E360) begin
         failures++;
         $display("FAIL vector_lane0: valid=%b lane0=%h, required 1 c368e360", a_out_valid, a_dataout[31:0]);
      end
      checks++;
      if (a_dataout !== exp) begin
         failures++;
         $display("FAIL vector_frame: got %h, required %h", a_dataout, exp);
      end
      checks++;
      if (a_somf !== 1'b1 || a_cnt !== 5'd0) begin
         failures++;
         $display("FAIL vector_somf: somf=%b cnt=%0d, required 1 0", a_somf, a_cnt);
      end
      next();
   endtask

   task automatic test_dummy();
      logic [127:0] exp;
      b_datain = 33'({$urandom, $urandom});
      b_ctrlin = 6'($urandom);
      b_datain[32:22] = 11'h7ff; b_ctrlin[5:4] = 2'b00;
      exp = model_frame(3, 2, 2'b00, 88'(b_datain), 16'(b_ctrlin), 0, 0);
      b_mode = 2'b00; b_in_valid = 1'b1; b_out_ready = 1'b1;
      next();
      b_in_valid = 1'b0;
      next();
      #1;
      checks++;
      if (b_out_valid !== 1'b1 || b_dataout[63:32] !== 32'hFFE0_0000) begin
         failures++;
         $display("FAIL dummy_lane1: valid=%b lane1=%h, required 1 ffe00000", b_out_valid, b_dataout[63:32]);
      end
      checks++;
      if (b_dataout !== exp[63:0]) begin
         failures++;
         $display("FAIL dummy_frame: got %h, required %h", b_dataout, exp[63:0]);
      end
      next();
   endtask

   task automatic test_ramp();
      logic [15:0]  w;
      logic [127:0] exp;
      logic [127:0] exp_norm;
      a_out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         rand_a();
         a_in_valid = (i < 3) || (i == 5) || (i == 6);
         a_mode = (i == 5) ? 2'b00 : 2'b01;
         if (i == 5) exp_norm = model_frame(8, 4, 2'b00, a_datain, a_ctrlin, 0, 0);
         #1;
         if (i >= 2 && i <= 4) begin
            w = 16'((i - 2) * 32);
            exp = {8{w}};
            checks++;
            if (a_out_valid !== 1'b1 || a_dataout !== exp) begin
               failures++;
               $display("FAIL ramp_beat%0d: valid=%b got %h, required %h", i - 2, a_out_valid, a_dataout, exp);
            end
         end
         if (i == 7) begin
            checks++;
            if (a_out_valid !== 1'b1 || a_dataout !== exp_norm) begin
               failures++;
               $display("FAIL ramp_normal: got %h, required %h", a_dataout, exp_norm);
            end
         end
         if (i == 8) begin
            checks++;
            if (a_out_valid !== 1'b1 || a_dataout !== 128'h0) begin
               failures++;
               $display("FAIL ramp_restart: got %h, required 0", a_dataout);
            end
         end
         next();
      end
      a_in_valid = 1'b0;
      a_mode = 2'b00;
   endtask

   task automatic test_backpressure();
      logic [127:0] e0, e1;
      a_mode = 2'b00;
      a_out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rand_a();
         a_in_valid = (i < 5);
         a_out_ready = (i >= 5);
         if (i == 0) e0 = model_frame(8, 4, 2'b00, a_datain, a_ctrlin, 0, 0);
         if (i == 1) e1 = model_frame(8, 4, 2'b00, a_datain, a_ctrlin, 0, 0);
         #1;
         if (i >= 2 && i <= 4) begin
            checks++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_dataout !== e0) begin
               failures++;
               $display("FAIL bp_hold%0d: in_ready=%b valid=%b got %h, required 0 1 %h",
                        i, a_in_ready, a_out_valid, a_dataout, e0);
            end
         end
         if (i == 5 || i == 6) begin
            checks++;
            if (a_out_valid !== 1'b1 || a_dataout !== ((i == 5) ? e0 : e1)) begin
               failures++;
               $display("FAIL bp_release%0d: valid=%b got %h, required 1 %h",
                        i - 5, a_out_valid, a_dataout, (i == 5) ? e0 : e1);
            end
         end
         if (i == 7) begin
            checks++;
            if (a_out_valid !== 1'b0) begin
               failures++;
               $display("FAIL bp_empty: out_valid=%b, required 0", a_out_valid);
            end
         end
         next();
      end
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
   endtask

   task automatic test_multiframe();
      logic [32:0]  bd [9];
      logic [5:0]   bc [9];
      logic [127:0] exp;
      int exp_cnt;
      b_mode = 2'b00; b_out_ready = 1'b1; b_in_valid = 1'b0;
      b_mf_clear = 1'b1;
      next();
      b_mf_clear = 1'b0;
      exp_cnt = 0;
      for (int i = 0; i < 11; i++) begin
         if (i < 9) begin
            bd[i] = 33'({$urandom, $urandom});
            bc[i] = 6'($urandom);
            b_datain = bd[i]; b_ctrlin = bc[i];
         end
         b_in_valid = (i < 9);
         b_mf_clear = (i == 8);
         #1;
         if (i >= 2) begin
            exp = model_frame(3, 2, 2'b00, 88'(bd[i-2]), 16'(bc[i-2]), 0, 0);
            checks++;
            if (b_out_valid !== 1'b1 || b_dataout !== exp[63:0]) begin
               failures++;
               $display("FAIL mf_data%0d: valid=%b got %h, required %h", i - 2, b_out_valid, b_dataout, exp[63:0]);
            end
            checks++;
            if (b_cnt !== 5'(exp_cnt) || b_somf !== (exp_cnt == 0)) begin
               failures++;
               $display("FAIL mf_cnt%0d: cnt=%0d somf=%b, required %0d %b",
                        i - 2, b_cnt, b_somf, exp_cnt, exp_cnt == 0);
            end
            exp_cnt = (i == 8) ? 0 : (exp_cnt + 1) % 4;
         end
         next();
      end
      b_in_valid = 1'b0;
      b_mf_clear = 1'b0;
   endtask

   task automatic test_reset_midstream();
      logic [127:0] exp;
      a_mode = 2'b00; a_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_a();
         a_in_valid = (i < 2);
         next();
      end
      a_in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (a_out_valid !== 1'b0 || a_dataout !== 128'h0 || a_cnt !== 5'd0 || a_in_ready !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid: valid=%b data=%h cnt=%0d in_ready=%b, required 0 0 0 0",
                  a_out_valid, a_dataout, a_cnt, a_in_ready);
      end
      next();
      rst_n = 1'b1;
      a_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rand_a();
         a_in_valid = (i == 0);
         if (i == 0) exp = model_frame(8, 4, 2'b00, a_datain, a_ctrlin, 0, 0);
         #1;
         if (i != 2) begin
            checks++;
            if (a_out_valid !== 1'b0) begin
               failures++;
               $display("FAIL rst_stale%0d: out_valid=%b, required 0", i, a_out_valid);
            end
         end else begin
            checks++;
            if (a_out_valid !== 1'b1 || a_dataout !== exp || a_cnt !== 5'd0) begin
               failures++;
               $display("FAIL rst_resume: valid=%b cnt=%0d got %h, required 1 0 %h",
                        a_out_valid, a_cnt, a_dataout, exp);
            end
         end
         next();
      end
      a_in_valid = 1'b0;
   endtask

   task automatic test_random();
      logic [127:0] expq [$];
      logic [127:0] e;
      logic [127:0] held;
      logic stall_prev;
      int cnt_m, ramp_m, par_m, sel;
      logic [1:0] mode_cur;
      a_in_valid = 1'b0; a_out_ready = 1'b1; a_mf_clear = 1'b1;
      next();
      a_mf_clear = 1'b0;
      cnt_m = 0; ramp_m = 0; par_m = 0;
      stall_prev = 1'b0; held = '0; mode_cur = 2'b00;
      for (int i = 0; i < 610; i++) begin
         if (i < 600) begin
            rand_a();
            if ($urandom_range(0, 5) == 0) begin
               sel = $urandom_range(0, 7);
               mode_cur = (sel < 4) ? 2'b00 : (sel < 6) ? 2'b01 : (sel == 6) ? 2'b10 : 2'b11;
            end
            a_mode = mode_cur;
            a_in_valid = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_mf_clear = ($urandom_range(0, 49) == 0);
         end else begin
            a_in_valid = 1'b0; a_out_ready = 1'b1; a_mf_clear = 1'b0;
         end
         #1;
         if (stall_prev) begin
            checks++;
            if (a_out_valid !== 1'b1 || a_dataout !== held) begin
               failures++;
               $display("FAIL rnd_hold@%0d: valid=%b got %h, required 1 %h", i, a_out_valid, a_dataout, held);
            end
         end
         if (a_in_valid && a_in_ready) begin
            expq.push_back(model_frame(8, 4, a_mode, a_datain, a_ctrlin, ramp_m, par_m));
            ramp_m = (a_mode == 2'b01) ? (ramp_m + 1) % 2048 : 0;
            par_m  = (a_mode == 2'b10) ? 1 - par_m : 0;
         end
         if (a_out_valid && a_out_ready) begin
            checks++;
            if (expq.size() == 0) begin
               failures++;
               $display("FAIL rnd_extra@%0d: got %h, required no frame", i, a_dataout);
            end else begin
               e = expq.pop_front();
               if (a_dataout !== e) begin
                  failures++;
                  $display("FAIL rnd_data@%0d: got %h, required %h", i, a_dataout, e);
               end
            end
            checks++;
            if (a_cnt !== 5'(cnt_m) || a_somf !== (cnt_m == 0)) begin
               failures++;
               $display("FAIL rnd_cnt@%0d: cnt=%0d somf=%b, required %0d %b", i, a_cnt, a_somf, cnt_m, cnt_m == 0);
            end
         end
         if (a_mf_clear) cnt_m = 0;
         else if (a_out_valid && a_out_ready) cnt_m = (cnt_m + 1) % 32;
         stall_prev = a_out_valid && !a_out_ready;
         held = a_dataout;
         next();
      end
      checks++;
      if (expq.size() != 0) begin
         failures++;
         $display("FAIL rnd_drain: %0d frames outstanding, required 0", expq.size());
      end
      a_in_valid = 1'b0;
      a_mf_clear = 1'b0;
   endtask

   initial begin
      test_reset();
      test_vector();
      test_dummy();
      test_ramp();
      test_backpressure();
      test_multiframe();
      test_reset_midstream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
